// File: rtl/ksa4_pkg.sv
// Shared types and helpers for the 4-bit pipelined Kogge-Stone adder.
// Generate/propagate pair plus the prefix combine operators.
package ksa4_pkg;

    localparam int WIDTH   = 4;
    localparam int LATENCY = 4;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // Black cell: group (G,P) of a high span merged with the adjacent low span.
    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    // Gray cell: only the group generate is needed once the span reaches bit 0.
    function automatic logic carry_combine(input pg_t hi, input logic lo_g);
        return hi.g | (hi.p & lo_g);
    endfunction

endpackage

// File: rtl/ksa4_prefix_cell.sv
// Kogge-Stone black cell: combines two adjacent (G,P) spans into one.
module ksa4_prefix_cell
    import ksa4_pkg::*;
(
    input  pg_t hi,
    input  pg_t lo,
    output pg_t grp
);

    assign grp = pg_combine(hi, lo);

endmodule

// File: rtl/ksa4_pipelined_adder.sv
// 4-stage pipelined 4-bit Kogge-Stone adder with carry-in, bit-level pad ports.
// Optional KSA4_OVERFLOW_EN adds ovf_Pad, the registered two's-complement overflow flag.
module ksa4_pipelined_adder
    import ksa4_pkg::*;
(
    input  logic GCLK_Pad,
    input  logic rst_Pad,
    input  logic a0_Pad,
    input  logic a1_Pad,
    input  logic a2_Pad,
    input  logic a3_Pad,
    input  logic b0_Pad,
    input  logic b1_Pad,
    input  logic b2_Pad,
    input  logic b3_Pad,
    input  logic cin_Pad,
    output logic sum0_Pad,
    output logic sum1_Pad,
    output logic sum2_Pad,
    output logic sum3_Pad,
    output logic cout_Pad
`ifdef KSA4_OVERFLOW_EN
    ,
    output logic ovf_Pad
`endif
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    assign a = {a3_Pad, a2_Pad, a1_Pad, a0_Pad};
    assign b = {b3_Pad, b2_Pad, b1_Pad, b0_Pad};

    // Stage 1: bitwise generate/propagate, carry-in folded into bit 0's generate.
    logic [WIDTH-1:0] g1;
    logic [WIDTH-1:0] p1;
    logic             cin1;

    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad) begin
            g1   <= '0;
            p1   <= '0;
            cin1 <= 1'b0;
        end else begin
            g1   <= {a[3:1] & b[3:1], (a[0] & b[0]) | ((a[0] ^ b[0]) & cin_Pad)};
            p1   <= a ^ b;
            cin1 <= cin_Pad;
        end
    end

    // Stage 2: span-1 prefix. Bits 2 and 3 keep their group propagate for stage 3.
    pg_t  s2_pg [3:2];
    logic s2_g1;

    for (genvar i = 2; i < WIDTH; i++) begin : g_span1
        ksa4_prefix_cell u_cell (
            .hi  ({g1[i],   p1[i]}),
            .lo  ({g1[i-1], p1[i-1]}),
            .grp (s2_pg[i])
        );
    end

    assign s2_g1 = carry_combine({g1[1], p1[1]}, g1[0]);

    logic [WIDTH-1:0] gg2;
    logic [3:2]       gp2;
    logic [WIDTH-1:0] p2;
    logic             cin2;

    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad) begin
            gg2  <= '0;
            gp2  <= '0;
            p2   <= '0;
            cin2 <= 1'b0;
        end else begin
            gg2  <= {s2_pg[3].g, s2_pg[2].g, s2_g1, g1[0]};
            gp2  <= {s2_pg[3].p, s2_pg[2].p};
            p2   <= p1;
            cin2 <= cin1;
        end
    end

    // Stage 3: span-2 prefix completes every group generate G[i:0].
    logic [WIDTH-1:0] gg3;
    logic [WIDTH-1:0] p3;
    logic             cin3;

    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad) begin
            gg3  <= '0;
            p3   <= '0;
            cin3 <= 1'b0;
        end else begin
            gg3  <= {carry_combine({gg2[3], gp2[3]}, gg2[1]),
                     carry_combine({gg2[2], gp2[2]}, gg2[0]),
                     gg2[1:0]};
            p3   <= p2;
            cin3 <= cin2;
        end
    end

    // Stage 4: sum bits from propagate XOR incoming carry; outputs come straight from here.
    logic [WIDTH-1:0] sum4;
    logic             cout4;

    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad) begin
            sum4  <= '0;
            cout4 <= 1'b0;
        end else begin
            sum4  <= p3 ^ {gg3[2:0], cin3};
            cout4 <= gg3[3];
        end
    end

    assign sum0_Pad = sum4[0];
    assign sum1_Pad = sum4[1];
    assign sum2_Pad = sum4[2];
    assign sum3_Pad = sum4[3];
    assign cout_Pad = cout4;

`ifdef KSA4_OVERFLOW_EN
    // Carry into the sign bit differs from carry out of it.
    logic ovf4;

    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad) begin
            ovf4 <= 1'b0;
        end else begin
            ovf4 <= gg3[2] ^ gg3[3];
        end
    end

    assign ovf_Pad = ovf4;
`endif

endmodule

// File: tb/tb_ksa4_pipelined_adder.sv
// Scoreboard bench for ksa4_pipelined_adder: directed spec vectors, a reset sweep and random stream.
module tb_ksa4_pipelined_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic cin = 1'b0;
  logic s0, s1, s2, s3, co;
  logic ov;

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  // {ovf, cout, sum[3:0]}; one entry per sampling edge, oldest is next on the outputs
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  ksa4_pipelined_adder dut (
    .GCLK_Pad (clk),
    .rst_Pad  (rst),
    .a0_Pad   (a[0]),
    .a1_Pad   (a[1]),
    .a2_Pad   (a[2]),
    .a3_Pad   (a[3]),
    .b0_Pad   (b[0]),
    .b1_Pad   (b[1]),
    .b2_Pad   (b[2]),
    .b3_Pad   (b[3]),
    .cin_Pad  (cin),
    .sum0_Pad (s0),
    .sum1_Pad (s1),
    .sum2_Pad (s2),
    .sum3_Pad (s3),
    .cout_Pad (co)
`ifdef KSA4_OVERFLOW_EN
    ,
    .ovf_Pad  (ov)
`endif
  );

`ifndef KSA4_OVERFLOW_EN
  assign ov = 1'b0;
`endif

  // Reference: plain integer addition; signed overflow from the signed range of the result.
  function automatic logic [5:0] ref_model(input logic [3:0] x, input logic [3:0] y, input logic c);
    int u;
    int sx;
    int sy;
    int ss;
    logic ovf;
    u  = int'(x) + int'(y) + int'(c);
    sx = (x >= 4'd8) ? int'(x) - 16 : int'(x);
    sy = (y >= 4'd8) ? int'(y) - 16 : int'(y);
    ss = sx + sy + int'(c);
    ovf = (ss > 7) || (ss < -8);
    return {ovf, u[4:0]};
  endfunction

  // Drive one operand set (or a reset) for one edge and record what it must produce.
  task automatic step(input logic [3:0] x, input logic [3:0] y, input logic c,
                      input logic r, input logic [5:0] exp_v);
    @(negedge clk);
    a   = x;
    b   = y;
    cin = c;
    rst = r;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < exp_q.size(); k++) begin
        if (k >= exp_q.size() - 3) exp_q[k] = '0;
      end
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(exp_v);
    end
  endtask

  task automatic op(input logic [3:0] x, input logic [3:0] y, input logic c);
    step(x, y, c, 1'b0, ref_model(x, y, c));
  endtask

  // Directed vector: the sum/cout pair is written out literally.
  task automatic op_lit(input logic [3:0] x, input logic [3:0] y, input logic c, input logic [4:0] lit);
    logic [5:0] m;
    m = ref_model(x, y, c);
    step(x, y, c, 1'b0, {m[5], lit});
  endtask

  // Just after a reset edge every output must already be 0.
  task automatic check_reset_state();
    #1;
    checks++;
    if ({ov, co, s3, s2, s1, s0} !== 6'b000000) begin
      failures++;
      $display("FAIL reset state t=%0t actual ovf/cout/sum=%b required=000000",
               $time, {ov, co, s3, s2, s1, s0});
    end
  endtask

  // Monitor: every cycle the outputs present one result.
  initial begin
    logic [5:0] exp_v;
    logic [5:0] act_v;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() >= 4) begin
        exp_v = exp_q.pop_front();
        act_v = {ov, co, s3, s2, s1, s0};
`ifndef KSA4_OVERFLOW_EN
        exp_v[5] = 1'b0;
`endif
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL result t=%0t actual ovf/cout/sum=%b required=%b", $time, act_v, exp_v);
        end
      end
    end
  end

  // Watchdog: the stimulus must finish well within this bound.
  initial begin
    #100000;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL timeout t=%0t stimulus did not complete", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    logic [3:0] x;
    logic [3:0] y;
    logic c;
    // Pipeline contents before the first edge are unknown; reset zeroes these slots.
    repeat (3) exp_q.push_back('0);

    for (int i = 0; i < 2; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1, '0);
      check_reset_state();
    end

    op_lit(4'd15, 4'd6, 1'b0, 5'b10101);
    op_lit(4'd0, 4'd0, 1'b0, 5'b00000);
    op_lit(4'd8, 4'd12, 1'b0, 5'b10100);
    op_lit(4'd11, 4'd1, 1'b0, 5'b01100);
    op_lit(4'd6, 4'd11, 1'b1, 5'b10010);
    op_lit(4'd15, 4'd15, 1'b1, 5'b11111);
    op_lit(4'd15, 4'd0, 1'b1, 5'b10000);
`ifdef KSA4_OVERFLOW_EN
    step(4'd7, 4'd1, 1'b0, 1'b0, 6'b101000);
    step(4'd8, 4'd8, 1'b0, 1'b0, 6'b110000);
`endif

    // Mid-operation reset: first two ops are flushed, third runs normally.
    op(4'd9, 4'd9, 1'b1);
    op(4'd3, 4'd14, 1'b0);
    step(4'd5, 4'd5, 1'b1, 1'b1, '0);
    check_reset_state();
    op_lit(4'd12, 4'd7, 1'b1, 5'b10100);

    for (int i = 0; i < 60; i++) begin
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      c = 1'($urandom_range(0, 1));
      step(x, y, c, ($urandom_range(0, 19) == 0), ref_model(x, y, c));
    end

    repeat (4) op(4'd0, 4'd0, 1'b0);
    done = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() > 3) begin
      failures++;
      $display("FAIL drain t=%0t %0d expected results never compared", $time, exp_q.size() - 3);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
